song_player: RTL and testbench

- Autonomous score reader for the keyboard/buzzer design: fetches encoded note entries from a synchronous song ROM and replays them with millisecond timing.
- Per entry it presents a note and octave with a valid strobe, standing in for the live key inputs that drive the buzzer and tube display.
- Sits between the song ROM and the tone/display path. Exposes playback status and the current entry index for the tubes.

---
 rtl/song_player.sv | 191 +++++++++++++++++++
 tb/tb_song_player.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/song_player.sv
// rtl/song_player.sv - song ROM sequencer replaying note entries with millisecond timing
module song_player #(
    parameter int TICK_CYCLES = 100000,
    parameter int ADDR_BITS   = 6,
    parameter int NOTE_BITS   = 4,
    parameter int LENGTH_BITS = 3,
    parameter int UNIT_MS     = 125,
    parameter int GAP_MS      = 20
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 stop,
    input  logic                                 pause,
    input  logic [ADDR_BITS-1:0]                 song_base,
    output logic [ADDR_BITS-1:0]                 rom_addr,
    input  logic [2+NOTE_BITS+LENGTH_BITS-1:0]   rom_data,
    output logic [NOTE_BITS-1:0]                 note_out,
    output logic [1:0]                           octave_out,
    output logic                                 note_valid,
    output logic                                 playing,
    output logic                                 paused,
    output logic                                 done,
    output logic [ADDR_BITS-1:0]                 cur_index
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int MW = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_SOUND, S_GAP, S_PAUSED, S_DONE
    } state_t;

    state_t                 state_q, state_d, resume_q, resume_d;
    logic [ADDR_BITS-1:0]   rom_addr_q, rom_addr_d, base_q, base_d, cur_index_q, cur_index_d;
    logic [NOTE_BITS-1:0]   note_q, note_d;
    logic [1:0]             oct_q, oct_d;
    logic                   nv_q, nv_d, playing_q, playing_d, paused_q, paused_d, done_q, done_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [MW-1:0]          ms_q, ms_d, target_q, target_d;

    logic [LENGTH_BITS-1:0] ent_len;
    logic [NOTE_BITS-1:0]   ent_note;
    logic [1:0]             ent_oct;
    logic                   tick, sound_end, gap_end, last_addr;
    logic [MW-1:0]          ms_inc;

    assign ent_len   = rom_data[LENGTH_BITS-1:0];
    assign ent_note  = rom_data[LENGTH_BITS +: NOTE_BITS];
    assign ent_oct   = rom_data[LENGTH_BITS+NOTE_BITS +: 2];
    assign tick      = (presc_q == PW'(TICK_CYCLES - 1));
    assign ms_inc    = ms_q + MW'(1);
    assign sound_end = tick && (ms_inc == target_q);
    assign gap_end   = tick && (ms_inc == MW'(GAP_MS));
    assign last_addr = &rom_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start) state_d = S_FETCH;
                S_FETCH:        state_d = S_LOAD;
                S_LOAD:         state_d = (ent_len == '0) ? S_DONE : S_SOUND;
                S_SOUND: begin
                    if (pause)          state_d = S_PAUSED;
                    else if (sound_end) state_d = S_GAP;
                end
                S_GAP: begin
                    if (gap_end)    state_d = last_addr ? S_DONE : S_FETCH;
                    else if (pause) state_d = S_PAUSED;
                end
                S_PAUSED:       if (!pause) state_d = resume_q;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    // The edge that enters PAUSED still advances the timers, so sounding time is preserved.
    always_comb begin
        rom_addr_d = rom_addr_q;
        base_d     = base_q;
        note_d     = note_q;
        oct_d      = oct_q;
        nv_d       = nv_q;
        presc_d    = presc_q;
        ms_d       = ms_q;
        target_d   = target_q;
        resume_d   = resume_q;
        done_d     = 1'b0;
        if (stop) begin
            nv_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        rom_addr_d = song_base;
                        base_d     = song_base;
                    end
                end
                S_LOAD: begin
                    if (ent_len != '0) begin
                        note_d   = ent_note;
                        oct_d    = ent_oct;
                        nv_d     = (ent_note != '0);
                        presc_d  = '0;
                        ms_d     = '0;
                        target_d = MW'(ent_len) * MW'(UNIT_MS) - MW'(GAP_MS);
                    end else begin
                        done_d = 1'b1;
                    end
                end
                S_SOUND: begin
                    presc_d  = tick ? '0 : presc_q + PW'(1);
                    ms_d     = tick ? ms_inc : ms_q;
                    resume_d = sound_end ? S_GAP : S_SOUND;
                    if (sound_end) begin
                        ms_d = '0;
                        nv_d = 1'b0;
                    end
                    if (pause) nv_d = 1'b0;
                end
                S_GAP: begin
                    presc_d  = tick ? '0 : presc_q + PW'(1);
                    ms_d     = tick ? ms_inc : ms_q;
                    resume_d = S_GAP;
                    if (gap_end) begin
                        ms_d = '0;
                        if (last_addr) done_d = 1'b1;
                        else           rom_addr_d = rom_addr_q + ADDR_BITS'(1);
                    end
                end
                S_PAUSED: begin
                    if (!pause) nv_d = (resume_q == S_SOUND) && (note_q != '0);
                end
                default: ;
            endcase
        end
        playing_d   = state_d inside {S_FETCH, S_LOAD, S_SOUND, S_GAP, S_PAUSED};
        paused_d    = (state_d == S_PAUSED);
        cur_index_d = rom_addr_d - base_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resume_q    <= S_IDLE;
            rom_addr_q  <= '0;
            base_q      <= '0;
            note_q      <= '0;
            oct_q       <= '0;
            nv_q        <= 1'b0;
            playing_q   <= 1'b0;
            paused_q    <= 1'b0;
            done_q      <= 1'b0;
            cur_index_q <= '0;
            presc_q     <= '0;
            ms_q        <= '0;
            target_q    <= '0;
        end else begin
            resume_q    <= resume_d;
            rom_addr_q  <= rom_addr_d;
            base_q      <= base_d;
            note_q      <= note_d;
            oct_q       <= oct_d;
            nv_q        <= nv_d;
            playing_q   <= playing_d;
            paused_q    <= paused_d;
            done_q      <= done_d;
            cur_index_q <= cur_index_d;
            presc_q     <= presc_d;
            ms_q        <= ms_d;
            target_q    <= target_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign note_out   = note_q;
    assign octave_out = oct_q;
    assign note_valid = nv_q;
    assign playing    = playing_q;
    assign paused     = paused_q;
    assign done       = done_q;
    assign cur_index  = cur_index_q;

endmodule

// File: tb/tb_song_player.sv
// tb/tb_song_player.sv - directed bench for song_player with a synchronous ROM model
module tb_song_player;

    logic       clk, rst, start, stop, pause;
    logic [5:0] song_base, rom_addr, cur_index;
    logic [8:0] rom_data;
    logic [3:0] note_out;
    logic [1:0] octave_out;
    logic       note_valid, playing, paused, done;

    logic [8:0] rom [64];

    int checks = 0;
    int errors = 0;
    int cyc, p_lo, p_hi, stop_at;
    logic [255:0] nv_v, pa_v, dn_v, pl_v;
    int no_a [256];
    int oc_a [256];
    int ci_a [256];
    int ra_a [256];

    song_player #(
        .TICK_CYCLES(10), .ADDR_BITS(6), .NOTE_BITS(4),
        .LENGTH_BITS(3), .UNIT_MS(4), .GAP_MS(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .song_base(song_base), .rom_addr(rom_addr), .rom_data(rom_data),
        .note_out(note_out), .octave_out(octave_out), .note_valid(note_valid),
        .playing(playing), .paused(paused), .done(done), .cur_index(cur_index)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ent(input logic [1:0] o, input logic [3:0] n, input logic [2:0] l);
        return {o, n, l};
    endfunction

    function automatic int cnt(input logic [255:0] v, input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) if (v[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int first(input logic [255:0] v);
        for (int i = 0; i < 256; i++) if (v[i] === 1'b1) return i;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 9'd0;
    endtask

    // Steps n cycles, logging outputs per cycle; pause window and stop cycle are driven here.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            cyc++;
            if (cyc == 1) start = 1'b0;
            nv_v[cyc] = note_valid;
            pa_v[cyc] = paused;
            dn_v[cyc] = done;
            pl_v[cyc] = playing;
            no_a[cyc] = int'(note_out);
            oc_a[cyc] = int'(octave_out);
            ci_a[cyc] = int'(cur_index);
            ra_a[cyc] = int'(rom_addr);
            pause = (cyc >= p_lo) && (cyc <= p_hi);
            stop  = (cyc == stop_at);
        end
    endtask

    task automatic kick(input logic [5:0] base, input int n);
        nv_v = '0; pa_v = '0; dn_v = '0; pl_v = '0;
        cyc = 0;
        song_base = base;
        start = 1'b1;
        run(n);
        p_lo = 1000; p_hi = 0; stop_at = -1;
        pause = 1'b0; stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; song_base = '0;
        p_lo = 1000; p_hi = 0; stop_at = -1;
        clear_rom();
        step(); step();
        check("rst_nv", note_valid, 0);
        check("rst_playing", playing, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        step();

        // single note then terminator
        clear_rom();
        rom[0] = ent(2'd1, 4'd5, 3'd2);
        kick(6'd0, 95);
        check("t2_nv_rise", first(nv_v), 3);
        check("t2_note", no_a[3], 5);
        check("t2_oct", oc_a[3], 1);
        check("t2_nv_len", cnt(nv_v, 3, 72), 70);
        check("t2_nv_total", cnt(nv_v, 0, 255), 70);
        check("t2_done_at", first(dn_v), 85);
        check("t2_done_cnt", cnt(dn_v, 0, 255), 1);
        check("t2_play_pre", pl_v[84], 1);
        check("t2_play_drop", pl_v[85], 0);
        check("t2_index", ci_a[85], 1);

        // rest entry then a real note
        clear_rom();
        rom[0] = ent(2'd0, 4'd0, 3'd1);
        rom[1] = ent(2'd2, 4'd3, 3'd1);
        kick(6'd0, 95);
        check("t3_rest_silent", cnt(nv_v, 1, 44), 0);
        check("t3_nv_rise", first(nv_v), 45);
        check("t3_nv_total", cnt(nv_v, 0, 255), 30);
        check("t3_note", no_a[45], 3);
        check("t3_oct", oc_a[45], 2);
        check("t3_idx0", ci_a[42], 0);
        check("t3_idx1", ci_a[43], 1);
        check("t3_idx2", ci_a[85], 2);
        check("t3_done_at", first(dn_v), 87);

        // pause 20 cycles into a len2 note
        clear_rom();
        rom[0] = ent(2'd1, 4'd7, 3'd2);
        p_lo = 22; p_hi = 46;
        kick(6'd0, 115);
        check("t4_nv_before", cnt(nv_v, 3, 22), 20);
        check("t4_paused_win", cnt(pa_v, 23, 47), 25);
        check("t4_paused_total", cnt(pa_v, 0, 255), 25);
        check("t4_nv_in_pause", cnt(nv_v, 23, 47), 0);
        check("t4_nv_resume", nv_v[48], 1);
        check("t4_nv_after", cnt(nv_v, 48, 97), 50);
        check("t4_nv_end", nv_v[98], 0);
        check("t4_nv_total", cnt(nv_v, 0, 255), 70);
        check("t4_done_at", first(dn_v), 110);

        // stop during GAP, then start+stop together
        clear_rom();
        rom[0] = ent(2'd1, 4'd2, 3'd1);
        rom[1] = ent(2'd1, 4'd4, 3'd1);
        stop_at = 35;
        kick(6'd0, 60);
        check("t5_play_pre", pl_v[35], 1);
        check("t5_play_stop", pl_v[36], 0);
        check("t5_play_after", cnt(pl_v, 36, 60), 0);
        check("t5_no_done", cnt(dn_v, 0, 255), 0);
        check("t5_nv_stop", nv_v[36], 0);
        song_base = 6'd5;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("t5_sim_play", playing, 0);
        step(); step();
        check("t5_sim_play2", playing, 0);
        check("t5_sim_addr", rom_addr, 0);

        // end-of-ROM without wrap
        for (int i = 0; i < 64; i++) rom[i] = ent(2'd1, 4'd1, 3'd1);
        kick(6'd62, 100);
        check("t6_addr_start", ra_a[1], 62);
        check("t6_addr_next", ra_a[43], 63);
        check("t6_idx1", ci_a[43], 1);
        check("t6_done_at", first(dn_v), 85);
        check("t6_done_cnt", cnt(dn_v, 0, 255), 1);
        check("t6_play_drop", pl_v[85], 0);
        check("t6_nv_total", cnt(nv_v, 0, 255), 60);
        begin
            int zeros = 0;
            for (int i = 1; i <= 100; i++) if (ra_a[i] == 0) zeros++;
            check("t6_no_wrap", zeros, 0);
        end

        // async reset in the middle of SOUND
        clear_rom();
        rom[3] = ent(2'd1, 4'd5, 3'd2);
        kick(6'd3, 10);
        check("t1_pre_nv", note_valid, 1);
        check("t1_pre_addr", rom_addr, 3);
        #2 rst = 1'b1;
        #1;
        check("t1_rst_nv", note_valid, 0);
        check("t1_rst_note", note_out, 0);
        check("t1_rst_oct", octave_out, 0);
        check("t1_rst_play", playing, 0);
        check("t1_rst_addr", rom_addr, 0);
        check("t1_rst_idx", cur_index, 0);
        #3 rst = 1'b0;
        step(); step();
        check("t1_idle_play", playing, 0);
        check("t1_idle_done", done, 0);
        check("t1_idle_nv", note_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
